// File: rtl/mul_functional_unit_pkg.sv
// Shared types for the iterative RV32M multiply unit: funct3 encodings, FSM states,
// the CDB output bundle and a magnitude helper used when latching operands.
package mul_functional_unit_pkg;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011
    } mul_funct3_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } mul_fsm_state_t;

    typedef struct packed {
        logic        valid;
        logic [2:0]  rob_id;
        logic [5:0]  rd_phys;
        logic [31:0] data;
    } fu_output_t;

    // Magnitude of a 32-bit operand; 0x80000000 maps to 2^31, which fits unsigned.
    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mul_functional_unit_shift_add_core.sv
// Unsigned 32x32->64 shift-add datapath retiring BITS_PER_CYCLE multiplier bits per cycle.
// done_o pulses for one cycle once the full product sits in product_o.
module mul_shift_add_core #(
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        load_i,
    input  logic [31:0] mcand_i,
    input  logic [31:0] mplier_i,
    output logic [63:0] product_o,
    output logic        done_o
);

    localparam int          N    = 32 / BITS_PER_CYCLE;
    localparam logic [5:0]  LAST = 6'(N - 1);

    logic [63:0] acc_q;
    logic [63:0] mcand_q;
    logic [31:0] mplier_q;
    logic [5:0]  cnt_q;
    logic        active_q;
    logic        done_q;
    logic [63:0] partial_d;

    always_comb begin
        partial_d = '0;
        for (int k = 0; k < BITS_PER_CYCLE; k++) begin
            if (mplier_q[k]) begin
                partial_d = partial_d + (mcand_q << k);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear_i) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else if (load_i) begin
            acc_q    <= '0;
            mcand_q  <= {32'd0, mcand_i};
            mplier_q <= mplier_i;
            cnt_q    <= '0;
            active_q <= 1'b1;
            done_q   <= 1'b0;
        end else if (active_q) begin
            acc_q    <= acc_q + partial_d;
            mcand_q  <= mcand_q << BITS_PER_CYCLE;
            mplier_q <= mplier_q >> BITS_PER_CYCLE;
            if (cnt_q == LAST) begin
                cnt_q    <= '0;
                active_q <= 1'b0;
                done_q   <= 1'b1;
            end else begin
                cnt_q <= cnt_q + 6'd1;
            end
        end else begin
            done_q <= 1'b0;
        end
    end

    assign product_o = acc_q;
    assign done_o    = done_q;

endmodule

// File: rtl/mul_functional_unit.sv
// RV32M multiply functional unit: sign handling, tag tracking and CDB writeback
// holding around the unsigned shift-add core.
module mul_functional_unit
    import mul_functional_unit_pkg::*;
#(
    parameter int ROB_ID_W       = 3,
    parameter int PREG_W         = 6,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                start,
    input  logic [ROB_ID_W-1:0] rob_id,
    input  logic [PREG_W-1:0]   rd_phys,
    input  logic [2:0]          funct3,
    input  logic [31:0]         rs1_v,
    input  logic [31:0]         rs2_v,
    output logic                fu_ready,
    output logic                wb_valid,
    output logic [ROB_ID_W-1:0] wb_rob_id,
    output logic [PREG_W-1:0]   wb_rd_phys,
    output logic [31:0]         wb_data,
    input  logic                wb_ack
);

    mul_fsm_state_t       state_q;
    logic [ROB_ID_W-1:0]  rob_id_q;
    logic [PREG_W-1:0]    rd_phys_q;
    logic                 neg_q;
    logic                 hi_q;
    logic                 zero_q;
    logic                 wb_valid_q;
    logic [ROB_ID_W-1:0]  wb_rob_id_q;
    logic [PREG_W-1:0]    wb_rd_phys_q;
    logic [31:0]          wb_data_q;

    logic                 rs1_signed_d;
    logic                 rs2_signed_d;
    logic                 core_load_d;
    logic [63:0]          product;
    logic                 core_done;
    logic [63:0]          signed_prod_d;
    logic [31:0]          result_d;

    assign rs1_signed_d = (funct3 == MULH) || (funct3 == MULHSU);
    assign rs2_signed_d = (funct3 == MULH);
    assign core_load_d  = (state_q == IDLE) && start && !flush;

    mul_shift_add_core #(
        .BITS_PER_CYCLE (BITS_PER_CYCLE)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (flush),
        .load_i    (core_load_d),
        .mcand_i   (abs32(rs1_v, rs1_signed_d)),
        .mplier_i  (abs32(rs2_v, rs2_signed_d)),
        .product_o (product),
        .done_o    (core_done)
    );

    // Divide encodings never reach here legitimately; they drain with a zero result.
    assign signed_prod_d = neg_q ? (~product + 64'd1) : product;
    assign result_d      = zero_q ? 32'd0 : (hi_q ? signed_prod_d[63:32] : signed_prod_d[31:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            rob_id_q     <= '0;
            rd_phys_q    <= '0;
            neg_q        <= 1'b0;
            hi_q         <= 1'b0;
            zero_q       <= 1'b0;
            wb_valid_q   <= 1'b0;
            wb_rob_id_q  <= '0;
            wb_rd_phys_q <= '0;
            wb_data_q    <= '0;
        end else if (flush) begin
            state_q    <= IDLE;
            wb_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        rob_id_q  <= rob_id;
                        rd_phys_q <= rd_phys;
                        neg_q     <= (rs1_signed_d & rs1_v[31]) ^ (rs2_signed_d & rs2_v[31]);
                        hi_q      <= (funct3[1:0] != 2'b00);
                        zero_q    <= funct3[2];
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    if (core_done) begin
                        wb_valid_q   <= 1'b1;
                        wb_rob_id_q  <= rob_id_q;
                        wb_rd_phys_q <= rd_phys_q;
                        wb_data_q    <= result_d;
                        state_q      <= DONE;
                    end
                end
                DONE: begin
                    if (wb_ack) begin
                        wb_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign fu_ready   = (state_q == IDLE);
    assign wb_valid   = wb_valid_q;
    assign wb_rob_id  = wb_rob_id_q;
    assign wb_rd_phys = wb_rd_phys_q;
    assign wb_data    = wb_data_q;

endmodule
